// File: rtl/pattern_loader.sv
// Serial frame loader: shifts in a 64-bit board pattern plus an even-parity bit,
// then writes the eight buffered rows to board memory if the parity checks out.
module pattern_loader (
  input  logic       ph1,
  input  logic       reset_n,
  input  logic       load_req,
  input  logic       ser_valid,
  input  logic       ser_data,
  output logic       ser_ready,
  output logic       mem_we,
  output logic [2:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RECV, PARITY, COMMIT} state_t;

  state_t     state;
  logic [5:0] bit_cnt;
  logic       parity;
  logic [7:0] row_buf [8];

  // bit_cnt indexes incoming data bits in RECV and counts issued row writes in COMMIT
  always_ff @(posedge ph1) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      parity    <= 1'b0;
      ser_ready <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (load_req) begin
            state     <= RECV;
            bit_cnt   <= '0;
            parity    <= 1'b0;
            ser_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RECV: begin
          if (ser_valid) begin
            row_buf[bit_cnt[5:3]][bit_cnt[2:0]] <= ser_data;
            parity  <= parity ^ ser_data;
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd63) state <= PARITY;
          end
        end
        PARITY: begin
          if (ser_valid) begin
            ser_ready <= 1'b0;
            if (parity ^ ser_data) begin
              state <= IDLE;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              // row 0 goes out immediately so the first write lands in the next cycle
              state     <= COMMIT;
              mem_we    <= 1'b1;
              mem_addr  <= 3'd0;
              mem_wdata <= row_buf[0];
              bit_cnt   <= 6'd1;
            end
          end
        end
        COMMIT: begin
          if (bit_cnt == 6'd8) begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= bit_cnt[2:0];
            mem_wdata <= row_buf[bit_cnt[2:0]];
            bit_cnt   <= bit_cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
// Self-checking bench for pattern_loader: a queue-based frame model predicts every
// output each cycle, and directed plus random frames pin board contents.
module tb_pattern_loader;

  logic       ph1 = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_req = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_data = 1'b0;
  logic       ser_ready, mem_we, busy, done, err;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;

  pattern_loader dut (
    .ph1(ph1), .reset_n(reset_n), .load_req(load_req),
    .ser_valid(ser_valid), .ser_data(ser_data), .ser_ready(ser_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 ph1 = ~ph1;
  always @(posedge ph1) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic reportTimeout(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: wait expired at cycle %0d", name, cyc);
  endtask

  // Behavioural model: collects accepted bits in a queue, checks parity by popcount
  // and replays the accepted word row by row.
  localparam int M_IDLE = 0, M_DATA = 1, M_PAR = 2, M_WRITE = 3;
  int          m_mode = M_IDLE;
  logic        m_bits[$];
  logic [63:0] m_word = '0;
  int          m_row = 0;
  logic        e_ready = 0, e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
  logic [2:0]  e_addr = '0;
  logic [7:0]  e_wdata = '0;

  always @(posedge ph1) begin
    e_done = 0; e_err = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    if (!reset_n) begin
      m_mode = M_IDLE; m_bits.delete(); e_ready = 0; e_busy = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (load_req) begin
          m_mode = M_DATA; m_bits.delete(); e_ready = 1; e_busy = 1;
        end
        M_DATA: if (ser_valid) begin
          m_bits.push_back(ser_data);
          if (m_bits.size() == 64) m_mode = M_PAR;
        end
        M_PAR: if (ser_valid) begin
          for (int i = 0; i < 64; i++) m_word[i] = m_bits[i];
          e_ready = 0;
          if ((($countones(m_word) + int'(ser_data)) % 2) == 0) begin
            m_mode = M_WRITE; m_row = 0; e_we = 1; e_addr = 3'd0; e_wdata = m_word[7:0];
          end else begin
            m_mode = M_IDLE; e_err = 1; e_busy = 0;
          end
        end
        M_WRITE: begin
          m_row++;
          if (m_row == 8) begin
            m_mode = M_IDLE; e_done = 1; e_busy = 0;
          end else begin
            e_we = 1; e_addr = m_row[2:0]; e_wdata = m_word[8*m_row +: 8];
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Per-cycle compare plus a capture of what the DUT actually wrote to the board
  logic [7:0] board [8];
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, first_we = -1;

  always @(negedge ph1) begin
    if (check_en) begin
      checkOutput("outputs", {ser_ready, mem_we, mem_addr, mem_wdata, busy, done, err},
                  {e_ready, e_we, e_addr, e_wdata, e_busy, e_done, e_err});
      if (mem_we === 1'b1) begin
        board[mem_addr] = mem_wdata;
        wr_cnt++;
        if (first_we < 0) first_we = cyc;
      end
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
    end
  end

  // Sends one frame; mode 0 = always valid, 1 = toggle from 1, 2 = random valid
  task automatic applyStimulus(input logic [63:0] data, input logic pbit, input int mode,
                               input int abort_after, input bit hold_load, output int first_xfer);
    logic [64:0] bits;
    int idx, guard;
    bit xfer, tog;
    bits = {pbit, data}; idx = 0; guard = 0; tog = 1; first_xfer = -1;
    load_req = 1;
    while (!e_ready && guard < 40) begin
      ser_valid = 1'($urandom_range(0, 1));
      ser_data  = 1'($urandom_range(0, 1));
      @(posedge ph1); #1;
      guard++;
    end
    if (!e_ready) begin
      reportTimeout("frame_start");
      ser_valid = 0;
      return;
    end
    if (!hold_load) load_req = 0;
    guard = 0;
    while (idx < 65 && (abort_after < 0 || idx < abort_after)) begin
      case (mode)
        0: ser_valid = 1;
        1: begin ser_valid = tog; tog = ~tog; end
        default: ser_valid = 1'($urandom_range(0, 1));
      endcase
      ser_data = bits[idx];
      xfer = ser_valid && e_ready;
      if (xfer && first_xfer < 0) first_xfer = cyc;
      @(posedge ph1); #1;
      if (xfer) idx++;
      guard++;
      if (guard > 600) begin
        reportTimeout("frame_bits");
        break;
      end
    end
    ser_valid = 0;
  endtask

  // Waits out COMMIT with noise on the serial lines; optionally pokes load_req early in COMMIT
  task automatic finishFrame(input bit poke_load);
    int guard;
    guard = 0;
    while (e_busy && guard < 20) begin
      ser_valid = 1'($urandom_range(0, 1));
      ser_data  = 1'($urandom_range(0, 1));
      if (poke_load) load_req = (m_mode == M_WRITE && m_row < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge ph1); #1;
      guard++;
    end
    ser_valid = 0;
    if (e_busy) reportTimeout("frame_end");
    @(negedge ph1); #1;
  endtask

  task automatic doReset();
    reset_n = 0;
    @(posedge ph1); #1;
    @(posedge ph1); #1;
    reset_n = 1;
  endtask

  task automatic fillBoard(input logic [7:0] v);
    for (int r = 0; r < 8; r++) board[r] = v;
  endtask

  task automatic checkBoard(input string name, input logic [63:0] exp);
    for (int r = 0; r < 8; r++) checkOutput(name, board[r], exp[8*r +: 8]);
  endtask

  logic [63:0] exp_board;
  logic [63:0] rdata;
  logic        pbit;
  int fx, w0, d0, e0, abort;

  initial begin
    repeat (2) @(posedge ph1);
    #1;
    check_en = 1;
    checkOutput("reset_state", {ser_ready, mem_we, mem_addr, mem_wdata, busy, done, err}, 0);
    reset_n = 1;
    @(posedge ph1); #1;

    // Glider frame with correct parity
    fillBoard(8'hAA); w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    applyStimulus(GLIDER, 1'b1, 0, -1, 0, fx);
    finishFrame(0);
    checkOutput("glider_model_word", m_word, 64'h0000_0000_0007_0402);
    checkBoard("glider_rows", {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h04, 8'h02});
    checkOutput("glider_writes", wr_cnt - w0, 8);
    checkOutput("glider_done", done_cnt - d0, 1);
    checkOutput("glider_err", err_cnt - e0, 0);
    exp_board = GLIDER;

    // Same frame with a bad parity bit: rejected, nothing written
    fillBoard(8'h55); w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    applyStimulus(GLIDER, 1'b0, 0, -1, 0, fx);
    finishFrame(0);
    checkOutput("parity_err_pulse", err_cnt - e0, 1);
    checkOutput("parity_err_writes", wr_cnt - w0, 0);
    checkOutput("parity_err_done", done_cnt - d0, 0);
    checkOutput("parity_err_row0", board[0], 8'h55);

    // Valid toggling every cycle: identical writes, 129 cycles to first write
    fillBoard(8'hAA); first_we = -1;
    applyStimulus(GLIDER, 1'b1, 1, -1, 0, fx);
    finishFrame(0);
    checkOutput("stall_latency", first_we - fx, 129);
    checkBoard("stall_rows", GLIDER);

    // Reset after 30 data bits, then an all-ones frame
    w0 = wr_cnt; d0 = done_cnt;
    applyStimulus(64'h1234_5678_9ABC_DEF0, 1'b0, 0, 30, 0, fx);
    doReset();
    checkOutput("abort_writes", wr_cnt - w0, 0);
    fillBoard(8'h00);
    applyStimulus({64{1'b1}}, 1'b0, 0, -1, 0, fx);
    finishFrame(0);
    checkBoard("ones_rows", {64{1'b1}});
    checkOutput("ones_done", done_cnt - d0, 1);

    // Back-to-back frames with load_req held high
    fillBoard(8'hAA); d0 = done_cnt;
    applyStimulus(64'h0, 1'b0, 0, -1, 1, fx);
    finishFrame(0);
    checkBoard("b2b_first_rows", 64'h0);
    applyStimulus(GLIDER, 1'b1, 2, -1, 1, fx);
    load_req = 0;
    finishFrame(0);
    checkBoard("b2b_second_rows", GLIDER);
    checkOutput("b2b_done", done_cnt - d0, 2);

    // load_req pulsed during COMMIT is ignored
    d0 = done_cnt;
    applyStimulus(GLIDER, 1'b1, 0, -1, 0, fx);
    finishFrame(1);
    load_req = 0;
    repeat (3) @(posedge ph1);
    #1;
    checkOutput("ignore_load_idle", busy, 1'b0);
    checkOutput("ignore_load_done", done_cnt - d0, 1);
    exp_board = GLIDER;

    // Random frames: good/bad parity, random stalls, occasional reset abort
    for (int n = 0; n < 12; n++) begin
      rdata = {$urandom, $urandom};
      pbit  = ($urandom_range(0, 3) == 0) ? ~^rdata : ^rdata;
      abort = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 64)) : -1;
      applyStimulus(rdata, pbit, 2, abort, 0, fx);
      if (abort >= 0) doReset();
      else begin
        finishFrame(1);
        load_req = 0;
        if (pbit == ^rdata) exp_board = rdata;
      end
      checkBoard("random_rows", exp_board);
    end

    repeat (2) @(posedge ph1);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
